sc_mult_ctrl: RTL

SC_MULT_CTRL -- requirements
Module: sc_mult_ctrl

---
 rtl/sc_mult_ctrl_pkg.sv | 32 +++
 rtl/sc_mult_ctrl_if.sv | 37 +++
 rtl/sc_mult_ctrl_lfsr.sv | 27 ++
 rtl/sc_mult_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sc_mult_ctrl_pkg.sv
// Shared definitions for the stochastic-computing multiplier controller.
// Holds the FSM state encoding, the 8-bit LFSR width, default seed and
// feedback tap mask (bits 7,5,4,3), plus the LFSR step and bit-reverse
// helpers used by both the LFSR sub-module and the controller.
package sc_pkg;

    localparam int          LFSR_W            = 8;
    localparam logic [7:0]  LFSR_DEFAULT_SEED = 8'h01;
    localparam logic [7:0]  LFSR_TAPS         = 8'b1011_1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    // One Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] r);
        return {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    endfunction

    // Bit-reversed copy of the random number decorrelates the second stream.
    function automatic logic [LFSR_W-1:0] bitrev(input logic [LFSR_W-1:0] x);
        logic [LFSR_W-1:0] y;
        for (int i = 0; i < LFSR_W; i++) begin
            y[i] = x[LFSR_W-1-i];
        end
        return y;
    endfunction

endpackage

// File: rtl/sc_mult_ctrl_if.sv
// Job/result handshake bundle of sc_mult_ctrl.
//   in_valid/in_ready + a, b, seed, len : job request
//   abort                               : cancel running job
//   out_valid/out_ready + result        : product ones-count
//   bs_a, bs_b, bs_p, bs_valid          : per-cycle stream bits
//   busy                                : job in progress
// master = job requester, slave = controller.
interface sc_mult_ctrl_if;
    import sc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [LFSR_W-1:0] a;
    logic [LFSR_W-1:0] b;
    logic [LFSR_W-1:0] seed;
    logic [LFSR_W-1:0] len;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [LFSR_W:0]   result;
    logic              bs_a;
    logic              bs_b;
    logic              bs_p;
    logic              bs_valid;
    logic              busy;

    modport master (
        output in_valid, a, b, seed, len, abort, out_ready,
        input  in_ready, out_valid, result, bs_a, bs_b, bs_p, bs_valid, busy
    );

    modport slave (
        input  in_valid, a, b, seed, len, abort, out_ready,
        output in_ready, out_valid, result, bs_a, bs_b, bs_p, bs_valid, busy
    );

endinterface

// File: rtl/sc_mult_ctrl_lfsr.sv
// sc_lfsr8: loadable 8-bit LFSR.
//   clk, reset (async, active-low), en (advance one step),
//   load (take load_val, has priority over en), load_val, q (current value).
module sc_lfsr8
    import sc_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/sc_mult_ctrl.sv
// sc_mult_ctrl: stochastic-computing multiplier controller.
// A job (a, b, seed, len) produces L = len (0 -> 256) random numbers r from
// an 8-bit LFSR; each cycle bs_a = r<a, bs_b = bitrev(r)<b and the AND of the
// two is accumulated. The ones-count is presented on result with a
// valid/ready handshake.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : sc_mult_ctrl_if.slave (job, abort, result, streams, busy)
module sc_mult_ctrl
    import sc_pkg::*;
#(
    parameter logic [7:0] DEFAULT_SEED = LFSR_DEFAULT_SEED,
    parameter int         W            = LFSR_W
) (
    input  logic         clk,
    input  logic         reset,
    sc_mult_ctrl_if.slave bus
);

    state_t       state;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] len_r;
    logic [W-1:0] seed_r;
    logic [W-1:0] cnt;
    logic [W:0]   ones;
    logic [W:0]   result_r;
    logic         bs_a_r;
    logic         bs_b_r;
    logic         bs_p_r;
    logic         bs_valid_r;

    logic [W-1:0] r;
    logic [W-1:0] load_val;
    logic [W-1:0] look;
    logic [W-1:0] len_m1;
    logic         cur_p;
    logic         la_a;
    logic         la_b;
    logic         last;

    assign load_val = (seed_r == '0) ? DEFAULT_SEED : seed_r;

    // The stream flops are loaded from the value r will hold next cycle, so
    // each registered bit lines up with the r value that produced it and the
    // stream stays confined to the RUN cycles.
    assign look   = (state == ST_LOAD) ? load_val : lfsr_step(r);
    assign la_a   = (look < a_r);
    assign la_b   = (bitrev(look) < b_r);
    assign cur_p  = (r < a_r) && (bitrev(r) < b_r);

    // len==0 wraps to 255 here, giving 256 RUN cycles.
    assign len_m1 = len_r - W'(1);
    assign last   = (cnt == len_m1);

    sc_lfsr8 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_RUN),
        .load     (state == ST_LOAD),
        .load_val (load_val),
        .q        (r)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            len_r      <= '0;
            seed_r     <= '0;
            cnt        <= '0;
            ones       <= '0;
            result_r   <= '0;
            bs_a_r     <= 1'b0;
            bs_b_r     <= 1'b0;
            bs_p_r     <= 1'b0;
            bs_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        len_r  <= bus.len;
                        seed_r <= bus.seed;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt        <= '0;
                        ones       <= '0;
                        bs_a_r     <= la_a;
                        bs_b_r     <= la_b;
                        bs_p_r     <= la_a & la_b;
                        bs_valid_r <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort || last) begin
                        bs_a_r     <= 1'b0;
                        bs_b_r     <= 1'b0;
                        bs_p_r     <= 1'b0;
                        bs_valid_r <= 1'b0;
                    end else begin
                        bs_a_r     <= la_a;
                        bs_b_r     <= la_b;
                        bs_p_r     <= la_a & la_b;
                    end
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        result_r <= ones + {{W{1'b0}}, cur_p};
                        state    <= ST_DONE;
                    end else begin
                        cnt  <= cnt + W'(1);
                        ones <= ones + {{W{1'b0}}, cur_p};
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_r;
    assign bus.bs_a      = bs_a_r;
    assign bus.bs_b      = bs_b_r;
    assign bus.bs_p      = bs_p_r;
    assign bus.bs_valid  = bs_valid_r;

endmodule
